// File: rtl/figo_route_ctrl_if.sv
// figo_route_ctrl_if: requester handshakes and room-FSM hop interface of the route controller
// slave  (controller): takes a/b valid+room and cur_room; drives ready, move_en/move_bit, busy and done reporting
// master (host/FSM side): the mirror image
interface figo_route_ctrl_if;
  logic       a_valid;
  logic [2:0] a_room;
  logic       a_ready;
  logic       b_valid;
  logic [2:0] b_room;
  logic       b_ready;
  logic [2:0] cur_room;
  logic       move_en;
  logic       move_bit;
  logic       busy;
  logic       done;
  logic       done_id;
  logic       done_err;
  logic [3:0] hop_count;
  modport slave (
    input  a_valid, a_room, b_valid, b_room, cur_room,
    output a_ready, b_ready, move_en, move_bit, busy, done, done_id, done_err, hop_count
  );
  modport master (
    output a_valid, a_room, b_valid, b_room, cur_room,
    input  a_ready, b_ready, move_en, move_bit, busy, done, done_id, done_err, hop_count
  );
endinterface

// File: rtl/figo_route_ctrl.sv
// figo_route_ctrl: arbitrates two room requests and walks the rover there one checked hop at a time
// ports: clk, reset (async active-low), bus (figo_route_ctrl_if.slave: requester handshakes,
//        cur_room from the room FSM, move_en/move_bit hop control, busy and done/done_id/done_err/hop_count)
module figo_route_ctrl #(
  parameter int MAX_HOPS = 7
) (
  input logic           clk,
  input logic           reset,
  figo_route_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, STEP, CHECK, DONE} state_t;
  // first hop bit of a shortest path, bit index {cur_room, target}; ties resolve to bit 0
  localparam logic [63:0] DIR = 64'h6900_C069_F7F0_F0FE;
  // room graph, index {room, bit}
  localparam logic [2:0] NXT [16] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3, 3'd4, 3'd3, 3'd0,
                                      3'd7, 3'd5, 3'd3, 3'd6, 3'd7, 3'd6, 3'd1, 3'd5};
  state_t     state, state_nxt;
  logic       rr, id, err;
  logic [2:0] target, expected, req_room;
  logic [3:0] hops;
  logic       a_win, b_win, accept, step_bit, mismatch, arrived, limit;
  // rr=0 gives A the tie; the pointer only moves when a tie is resolved
  always_comb begin
    a_win    = bus.a_valid & (~bus.b_valid | ~rr);
    b_win    = bus.b_valid & (~bus.a_valid | rr);
    accept   = (state == IDLE) & (a_win | b_win);
    req_room = b_win ? bus.b_room : bus.a_room;
    step_bit = DIR[{bus.cur_room, target}];
    mismatch = bus.cur_room != expected;
    arrived  = bus.cur_room == target;
    limit    = hops == 4'(MAX_HOPS);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = !accept ? IDLE : (req_room == bus.cur_room) ? DONE : STEP;
      STEP:    state_nxt = CHECK;
      CHECK:   state_nxt = (mismatch | arrived | limit) ? DONE : STEP;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.a_ready   = (state == IDLE) & a_win;
    bus.b_ready   = (state == IDLE) & b_win;
    bus.move_en   = state == STEP;
    bus.move_bit  = (state == STEP) & step_bit;
    bus.busy      = state != IDLE;
    bus.done      = state == DONE;
    bus.done_id   = id;
    bus.done_err  = err;
    bus.hop_count = hops;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rr       <= 1'b0;
      id       <= 1'b0;
      err      <= 1'b0;
      target   <= '0;
      expected <= '0;
      hops     <= '0;
    end else begin
      if (accept) begin
        target <= req_room;
        id     <= b_win;
        err    <= 1'b0;
        hops   <= '0;
        if (bus.a_valid & bus.b_valid) rr <= ~rr;
      end
      if (state == STEP) begin
        expected <= NXT[{bus.cur_room, step_bit}];
        hops     <= hops + 4'd1;
      end
      // a wrong room always fails; running out of hops fails only if not already there
      if (state == CHECK) err <= mismatch | (~arrived & limit);
    end
endmodule

// File: tb/tb_figo_route_ctrl.sv
module tb_figo_route_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  figo_route_ctrl_if bus1 ();
  figo_route_ctrl_if bus2 ();
  figo_route_ctrl dut1 (.clk(clk), .reset(reset), .bus(bus1));
  figo_route_ctrl #(.MAX_HOPS(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  localparam logic [2:0] G [16] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3, 3'd4, 3'd3, 3'd0,
                                    3'd7, 3'd5, 3'd3, 3'd6, 3'd7, 3'd6, 3'd1, 3'd5};
  logic [2:0] room1, room2, set_val;
  logic       set_en;
  always @(posedge clk) room1 <= set_en ? set_val : (bus1.move_en ? G[{room1, bus1.move_bit}] : room1);
  always @(posedge clk or negedge reset)
    if (!reset) room2 <= '0;
    else if (bus2.move_en) room2 <= G[{room2, bus2.move_bit}];
  assign bus1.cur_room = room1;
  assign bus2.cur_room = room2;
  int n_tests = 0;
  int n_fail = 0;
  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic set_room(input logic [2:0] r);
    @(negedge clk);
    set_en = 1'b1;
    set_val = r;
    @(negedge clk);
    set_en = 1'b0;
  endtask
  task automatic do_route(input logic sel, input logic [2:0] tgt, output int lat, output logic [7:0] bits,
                          output int n, output logic dn, output logic id, output logic err, output logic [3:0] hc);
    int w;
    bits = '0;
    n = 0;
    lat = 0;
    w = 0;
    @(negedge clk);
    if (sel) begin bus1.b_valid = 1'b1; bus1.b_room = tgt; end
    else begin bus1.a_valid = 1'b1; bus1.a_room = tgt; end
    #1;
    while (!(sel ? bus1.b_ready : bus1.a_ready) && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("accept_wait", int'(w < 20), 1);
    @(negedge clk);
    bus1.a_valid = 1'b0;
    bus1.b_valid = 1'b0;
    #1;
    lat = 1;
    while (!bus1.done && lat < 40) begin
      if (bus1.move_en) begin
        if (n < 8) bits[n] = bus1.move_bit;
        n++;
      end
      @(negedge clk);
      #1;
      lat++;
    end
    dn = bus1.done;
    id = bus1.done_id;
    err = bus1.done_err;
    hc = bus1.hop_count;
  endtask
  typedef struct {
    logic       sel;
    logic [2:0] start;
    logic [2:0] tgt;
    logic [7:0] bits;
    int         n;
  } vec_t;
  vec_t v [8];
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, n;
    logic [7:0] bits;
    logic dn, id, err;
    logic [3:0] hc;
    bit saw_done;
    v[0] = '{1'b0, 3'd0, 3'd6, 8'h0F, 4};
    v[1] = '{1'b0, 3'd0, 3'd3, 8'h01, 3};
    v[2] = '{1'b1, 3'd6, 3'd0, 8'h0A, 4};
    v[3] = '{1'b0, 3'd3, 3'd3, 8'h00, 0};
    v[4] = '{1'b1, 3'd4, 3'd2, 8'h00, 3};
    v[5] = '{1'b0, 3'd5, 3'd4, 8'h0E, 4};
    v[6] = '{1'b0, 3'd3, 3'd6, 8'h1F, 5};
    v[7] = '{1'b1, 3'd2, 3'd1, 8'h06, 3};
    {bus1.a_valid, bus1.b_valid, bus2.a_valid, bus2.b_valid} = '0;
    {bus1.a_room, bus1.b_room, bus2.a_room, bus2.b_room} = '0;
    set_en = 1'b0;
    set_val = '0;
    set_room(3'd0);
    #1;
    check("rst_a_ready", int'(bus1.a_ready), 0);
    check("rst_b_ready", int'(bus1.b_ready), 0);
    check("rst_move_en", int'(bus1.move_en), 0);
    check("rst_move_bit", int'(bus1.move_bit), 0);
    check("rst_busy", int'(bus1.busy), 0);
    check("rst_done", int'(bus1.done), 0);
    check("rst_done_id", int'(bus1.done_id), 0);
    check("rst_done_err", int'(bus1.done_err), 0);
    check("rst_hop_count", int'(bus1.hop_count), 0);
    @(negedge clk);
    reset = 1'b1;
    // MAX_HOPS=2 instance: R0->R6 needs 4 hops, so it aborts after 2
    @(negedge clk);
    bus2.a_valid = 1'b1;
    bus2.a_room = 3'd6;
    #1;
    check("max_accept", int'(bus2.a_ready), 1);
    @(negedge clk);
    bus2.a_valid = 1'b0;
    #1;
    lat = 1;
    while (!bus2.done && lat < 40) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check("max_latency", lat, 5);
    check("max_done_err", int'(bus2.done_err), 1);
    check("max_hop_count", int'(bus2.hop_count), 2);
    check("max_room", int'(room2), 4);
    // arbitration: tie after reset goes to A, then B; second tie goes to B
    @(negedge clk);
    bus1.a_valid = 1'b1; bus1.a_room = 3'd0;
    bus1.b_valid = 1'b1; bus1.b_room = 3'd0;
    #1;
    check("tie1_a_ready", int'(bus1.a_ready), 1);
    check("tie1_b_ready", int'(bus1.b_ready), 0);
    @(negedge clk);
    bus1.a_valid = 1'b0;
    #1;
    check("tie1_done", int'(bus1.done), 1);
    check("tie1_done_id", int'(bus1.done_id), 0);
    check("tie1_b_held_in_done", int'(bus1.b_ready), 0);
    @(negedge clk);
    #1;
    check("tie1_b_ready_next", int'(bus1.b_ready), 1);
    @(negedge clk);
    bus1.b_valid = 1'b0;
    #1;
    check("tie1_b_done_id", int'(bus1.done_id), 1);
    @(negedge clk);
    bus1.a_valid = 1'b1;
    bus1.b_valid = 1'b1;
    #1;
    check("tie2_b_ready", int'(bus1.b_ready), 1);
    check("tie2_a_ready", int'(bus1.a_ready), 0);
    @(negedge clk);
    bus1.b_valid = 1'b0;
    #1;
    check("tie2_done_id", int'(bus1.done_id), 1);
    check("tie2_a_held_in_done", int'(bus1.a_ready), 0);
    @(negedge clk);
    #1;
    check("tie2_a_ready_next", int'(bus1.a_ready), 1);
    @(negedge clk);
    bus1.a_valid = 1'b0;
    #1;
    check("tie2_a_done_id", int'(bus1.done_id), 0);
    for (int i = 0; i < 8; i++) begin
      set_room(v[i].start);
      do_route(v[i].sel, v[i].tgt, lat, bits, n, dn, id, err, hc);
      check($sformatf("v%0d_latency", i), lat, 2 * v[i].n + 1);
      check($sformatf("v%0d_done", i), int'(dn), 1);
      check($sformatf("v%0d_hop_count", i), int'(hc), v[i].n);
      check($sformatf("v%0d_moves", i), n, v[i].n);
      check($sformatf("v%0d_bits", i), int'(bits), int'(v[i].bits));
      check($sformatf("v%0d_done_err", i), int'(err), 0);
      check($sformatf("v%0d_done_id", i), int'(id), int'(v[i].sel));
      check($sformatf("v%0d_room", i), int'(room1), int'(v[i].tgt));
    end
    // rover lands in R2 instead of the expected R1
    set_room(3'd0);
    @(negedge clk);
    bus1.a_valid = 1'b1;
    bus1.a_room = 3'd6;
    #1;
    check("bad_accept", int'(bus1.a_ready), 1);
    @(negedge clk);
    bus1.a_valid = 1'b0;
    #1;
    check("bad_step", int'(bus1.move_en), 1);
    set_en = 1'b1;
    set_val = 3'd2;
    @(negedge clk);
    set_en = 1'b0;
    #1;
    check("bad_check_no_done", int'(bus1.done), 0);
    @(negedge clk);
    #1;
    check("bad_done", int'(bus1.done), 1);
    check("bad_done_err", int'(bus1.done_err), 1);
    check("bad_hop_count", int'(bus1.hop_count), 1);
    // reset in the middle of a route
    set_room(3'd0);
    @(negedge clk);
    bus1.a_valid = 1'b1;
    bus1.a_room = 3'd6;
    @(negedge clk);
    bus1.a_valid = 1'b0;
    #1;
    check("rstmid_step", int'(bus1.move_en), 1);
    reset = 1'b0;
    #1;
    check("rstmid_busy", int'(bus1.busy), 0);
    check("rstmid_move_en", int'(bus1.move_en), 0);
    @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (bus1.done || bus1.busy) saw_done = 1'b1;
    end
    check("rstmid_no_done", int'(saw_done), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
